vector_alu_issue: RTL
=====================

# vector_alu_issue

Registered ALU-control decoder and lane sequencer between decode and the SIMD execute stage. Accepts one instruction (Opcode, Func, ALUOp, vector length) per valid/ready handshake, decodes the 3-bit ALU control, and issues it as a single beat (scalar) or as ceil(vl/GROUP) lane-group beats (vector), with tail masking and downstream backpressure.

## Interface
- LANES, 16, total vector lanes (one per AES state byte); multiple of GROUP
- GROUP, 4, lanes executed per beat; power of two, 1..LANES
- VL_W, $clog2(LANES+1), width of vector-length input
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept instruction this cycle
- in_opcode  in  6  instruction opcode
- in_func  in  3  function field (R-type only)
- in_aluop  in  1  0 forces ADD control
- in_vl  in  VL_W  active lanes; 0 or >LANES clamps to LANES
- out_valid  out  1  beat present
- out_ready  in  1  execute stage accepts beat
- out_ctrl  out  3  ALU control (000 ADD, 001 SUB, 010 MUL, others = Func pass-through)
- out_lane_base  out  $clog2(LANES)  first lane of this beat
- out_lane_mask  out  GROUP  lane-enable bits, bit i = lane base+i
- out_scalar  out  1  beat is scalar (mask = 1, base = 0)
- out_last  out  1  final beat of instruction
- illegal  out  1  one-cycle pulse: unknown opcode with in_aluop=1

## Operation
- Decode (in_aluop=1): 000000 scalar R → Func; 100000 vector R → Func; 001000 ADDI → 000; 001010 MULI → 010; 000100 BEQ → 001; other opcodes → illegal. in_aluop=0 → 000, never illegal, scalar.
- Vector = opcode[5]=1 (only 100000 with aluop=1); everything else scalar.
- FSM: IDLE, ISSUE.
- IDLE: in_ready=1. On accept: legal → load ctrl, base=0, remaining=clamped vl (scalar: 1 beat), go ISSUE. Illegal → illegal=1 next cycle, stay IDLE, no beat.
- ISSUE: out_valid=1; outputs held stable while out_ready=0. On out_ready: if out_last → IDLE, else base += GROUP, remaining -= GROUP.
- Mask: remaining ≥ GROUP → all ones; else low `remaining` bits set. out_last = remaining ≤ GROUP.
- Back-to-back: in_ready also 1 in ISSUE when out_last & out_ready; new instruction loads in same cycle, no bubble.

## Timing
- Reset: state IDLE; out_valid, out_ctrl, out_lane_base, out_lane_mask, out_scalar, out_last, illegal all 0; in_ready 0 during reset cycle, 1 the cycle after.
- Latency: accept at edge t → first beat out_valid at t+1. Illegal pulse at t+1 for exactly one cycle.
- Throughput: one beat per cycle with out_ready=1; vector vl=16, GROUP=4 occupies 4 cycles.
- out_valid never drops without out_ready handshake (except reset). in_ready is combinational from state/out_ready/out_last only, never from in_valid.
- rst mid-ISSUE: beat abandoned, all outputs 0 next cycle, in-flight instruction discarded.
- Base never wraps: final base ≤ LANES-GROUP.

## Structure
- Package alu_pkg: ALU control constants (ALU_ADD, ALU_SUB, ALU_MUL), opcode constants (OP_RTYPE, OP_VRTYPE, OP_ADDI, OP_MULI, OP_BEQ), FSM state enum.
- Sub-module alu_ctrl_decode: combinational opcode/func/aluop → {ctrl, vector, illegal}; the sequencer registers its outputs.

## Test plan
- Scalar SUB: opcode 000000, func 001, aluop 1 → one beat, ctrl 001, scalar 1, mask 0001, last 1, at t+1.
- Vector MUL vl=16, GROUP=4: opcode 100000, func 010 → 4 beats, bases 0/4/8/12, masks 1111, last only on 4th.
- Tail: vector ADD vl=6 → 2 beats, masks 1111 then 0011; vl=0 → 4 full beats.
- Backpressure: out_ready low 3 cycles on beat 2 → outputs frozen, in_ready 0; resumes with base 4.
- Illegal opcode 111111, aluop 1 → illegal pulse 1 cycle, out_valid 0; aluop 0 same opcode → ADD scalar beat, no illegal.
- Back-to-back ADDI then BEQ with out_ready=1 → ctrl 000 at t+1, 001 at t+2; rst during vector beat 2 → all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, decoded opcodes and sequencer state for vector_alu_issue
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_VRTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_MULI = 6'b001010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode/func/aluop -> ALU control, vector flag, illegal flag
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [2:0] func,
  input  logic       aluop,
  output logic [2:0] ctrl,
  output logic       vector,
  output logic       illegal
);
  always_comb begin
    ctrl = ALU_ADD;
    vector = 1'b0;
    illegal = 1'b0;
    if (aluop) begin
      case (opcode)
        OP_RTYPE: ctrl = func;
        OP_VRTYPE: begin
          ctrl = func;
          vector = 1'b1;
        end
        OP_ADDI: ctrl = ALU_ADD;
        OP_MULI: ctrl = ALU_MUL;
        OP_BEQ: ctrl = ALU_SUB;
        default: illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/vector_alu_issue.sv
// vector_alu_issue: accepts one instruction per handshake and issues its ALU control as scalar or lane-group beats
module vector_alu_issue
  import alu_pkg::*;
#(
  parameter int LANES = 16,
  parameter int GROUP = 4,
  parameter int VL_W = $clog2(LANES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic [2:0]               in_func,
  input  logic                     in_aluop,
  input  logic [VL_W-1:0]          in_vl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_ctrl,
  output logic [$clog2(LANES)-1:0] out_lane_base,
  output logic [GROUP-1:0]         out_lane_mask,
  output logic                     out_scalar,
  output logic                     out_last,
  output logic                     illegal
);
  localparam int BW = $clog2(LANES);
  state_t state_q, state_d;
  logic [2:0] ctrl_q, ctrl_d, dec_ctrl;
  logic [BW-1:0] base_q, base_d;
  logic [VL_W-1:0] rem_q, rem_d, vl_clamp;
  logic scalar_q, scalar_d, ill_q, ill_d, dec_vec, dec_ill, busy, last, accept;
  alu_ctrl_decode u_dec (
    .opcode(in_opcode),
    .func(in_func),
    .aluop(in_aluop),
    .ctrl(dec_ctrl),
    .vector(dec_vec),
    .illegal(dec_ill)
  );
  assign busy = state_q == ISSUE;
  assign last = busy && rem_q <= VL_W'(GROUP);
  // reset gates in_ready so nothing is accepted in the reset cycle
  assign in_ready = !rst && (!busy || (last && out_ready));
  assign accept = in_valid && in_ready;
  assign vl_clamp = (in_vl == '0 || in_vl > VL_W'(LANES)) ? VL_W'(LANES) : in_vl;
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    base_d = base_q;
    rem_d = rem_q;
    scalar_d = scalar_q;
    ill_d = 1'b0;
    if (busy && out_ready) begin
      state_d = last ? IDLE : ISSUE;
      base_d = base_q + BW'(GROUP);
      rem_d = rem_q - VL_W'(GROUP);
    end
    // a new accept overrides the retiring beat, giving bubble-free back-to-back issue
    if (accept) begin
      ill_d = dec_ill;
      if (!dec_ill) begin
        state_d = ISSUE;
        ctrl_d = dec_ctrl;
        base_d = '0;
        rem_d = dec_vec ? vl_clamp : VL_W'(1);
        scalar_d = !dec_vec;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      base_q <= '0;
      rem_q <= '0;
      scalar_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      base_q <= base_d;
      rem_q <= rem_d;
      scalar_q <= scalar_d;
      ill_q <= ill_d;
    end
  end
  assign out_valid = busy;
  assign out_ctrl = busy ? ctrl_q : '0;
  assign out_lane_base = busy ? base_q : '0;
  // shifting past the group width leaves zero, so a full group falls out naturally
  assign out_lane_mask = busy ? ~({GROUP{1'b1}} << rem_q) : '0;
  assign out_scalar = busy && scalar_q;
  assign out_last = last;
  assign illegal = ill_q;
endmodule
